// File: rtl/seg_scan_driver_pkg.sv
// Shared types for the segment scan driver: segment pattern type and scan FSM states.
package seg_scan_driver_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } scan_state_e;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Write bus from the decoder stage into the scan driver's digit buffer.
interface seg_scan_driver_if #(
  parameter int IDXW = 2
);
  import seg_scan_driver_pkg::*;

  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  seg_t            wr_seg;

  modport master (output wr_en, wr_idx, wr_seg);
  modport slave  (input  wr_en, wr_idx, wr_seg);

endinterface

// File: rtl/seg_scan_driver_dwell_timer.sv
// Loadable down-counter; done flags the last cycle of a loaded interval (count == 1).
module seg_scan_driver_dwell_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: per-digit pattern buffer, dwell/blank timing,
// registered one-hot anode and segment outputs with configurable polarity.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | display dark, index 0, timer cleared
//   SHOW  | digit scan_idx lit for DWELL cycles
//   BLANK | all digits off for BLANK_CYC cycles, then advance and SHOW
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int DWELL       = 1000,
  parameter int BLANK_CYC   = 16,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit AN_ACT_LOW  = 1'b1,
  localparam int IDXW       = $clog2(NDIG)
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_driver_if.slave   wr,
  input  logic               disp_en,
  output seg_t               seg_o,
  output logic [NDIG-1:0]    an_o,
  output logic [IDXW-1:0]    scan_idx,
  output logic               frame_tick
);

  localparam int TMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]   T_DWELL  = TW'(DWELL);
  localparam logic [TW-1:0]   T_BLANK  = TW'(BLANK_CYC);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_IDLE  = AN_ACT_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};
  localparam seg_t            SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;

  scan_state_e     state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            first_q, first_d;
  logic            tick_d;
  logic            tmr_load, tmr_done;
  logic [TW-1:0]   tmr_val;
  seg_t            buf_q [NDIG];
  seg_t            seg_sel, seg_d;
  logic [NDIG-1:0] an_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDIG; i++) buf_q[i] <= SEG_OFF;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (wr.wr_en && (wr.wr_idx == IDXW'(i))) buf_q[i] <= wr.wr_seg;
      end
    end
  end

  seg_scan_driver_dwell_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_val),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      first_q <= first_d;
    end
  end

  // first_q suppresses the index advance on the BLANK that follows IDLE
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    first_d  = first_q;
    tick_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!disp_en) begin
      state_d  = IDLE;
      idx_d    = '0;
      first_d  = 1'b0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          idx_d    = '0;
          tmr_load = 1'b1;
          if (BLANK_CYC == 0) begin
            state_d = SHOW;
            tmr_val = T_DWELL;
          end else begin
            state_d = BLANK;
            tmr_val = T_BLANK;
            first_d = 1'b1;
          end
        end
        SHOW: begin
          if (tmr_done) begin
            tmr_load = 1'b1;
            if (BLANK_CYC == 0) begin
              idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
              tick_d  = (idx_q == IDX_LAST);
              tmr_val = T_DWELL;
            end else begin
              state_d = BLANK;
              tmr_val = T_BLANK;
            end
          end
        end
        BLANK: begin
          if (tmr_done) begin
            state_d  = SHOW;
            tmr_load = 1'b1;
            tmr_val  = T_DWELL;
            first_d  = 1'b0;
            if (!first_q) begin
              idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
              tick_d = (idx_q == IDX_LAST);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    seg_sel = SEG_OFF;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_d == IDXW'(i)) seg_sel = buf_q[i];
    end
    seg_d = (state_d == SHOW) ? seg_sel : SEG_OFF;
    an_d  = (state_d == SHOW) ? (NDIG'(1) << idx_d) : '0;
  end

  // Outputs are built from next-state values so anode and segments switch on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o      <= SEG_IDLE;
      an_o       <= AN_IDLE;
      frame_tick <= 1'b0;
    end else begin
      seg_o      <= SEG_ACT_LOW ? ~seg_d : seg_d;
      an_o       <= AN_ACT_LOW ? ~an_d : an_d;
      frame_tick <= tick_d;
    end
  end

  assign scan_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: three builds (4-digit blanked, 2-digit no-blank,
// 5-digit inverted polarity) exercised by per-scenario tasks.
module tb_seg_scan_driver;
  import seg_scan_driver_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // A: NDIG=4, DWELL=4, BLANK_CYC=2, active-low anodes
  seg_scan_driver_if #(.IDXW(2)) a_if ();
  logic a_dis;
  seg_t a_seg;
  logic [3:0] a_an;
  logic [1:0] a_idx;
  logic a_tick;
  seg_scan_driver #(.NDIG(4), .DWELL(4), .BLANK_CYC(2), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr(a_if), .disp_en(a_dis),
    .seg_o(a_seg), .an_o(a_an), .scan_idx(a_idx), .frame_tick(a_tick));

  // B: NDIG=2, DWELL=3, no blanking
  seg_scan_driver_if #(.IDXW(1)) b_if ();
  logic b_dis;
  seg_t b_seg;
  logic [1:0] b_an;
  logic [0:0] b_idx;
  logic b_tick;
  seg_scan_driver #(.NDIG(2), .DWELL(3), .BLANK_CYC(0), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .wr(b_if), .disp_en(b_dis),
    .seg_o(b_seg), .an_o(b_an), .scan_idx(b_idx), .frame_tick(b_tick));

  // C: NDIG=5, DWELL=4, BLANK_CYC=2, active-low segments, active-high anodes
  seg_scan_driver_if #(.IDXW(3)) c_if ();
  logic c_dis;
  seg_t c_seg;
  logic [4:0] c_an;
  logic [2:0] c_idx;
  logic c_tick;
  seg_scan_driver #(.NDIG(5), .DWELL(4), .BLANK_CYC(2), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .wr(c_if), .disp_en(c_dis),
    .seg_o(c_seg), .an_o(c_an), .scan_idx(c_idx), .frame_tick(c_tick));

  task automatic test_reset_values();
    @(negedge clk);
    checks++; if (a_seg !== 7'h00) begin failures++; $display("FAIL rst_a_seg got %h exp 00", a_seg); end
    checks++; if (a_an !== 4'hF) begin failures++; $display("FAIL rst_a_an got %h exp F", a_an); end
    checks++; if (a_idx !== 2'd0) begin failures++; $display("FAIL rst_a_idx got %0d exp 0", a_idx); end
    checks++; if (a_tick !== 1'b0) begin failures++; $display("FAIL rst_a_tick got %b exp 0", a_tick); end
    checks++; if (b_an !== 2'b11) begin failures++; $display("FAIL rst_b_an got %b exp 11", b_an); end
    checks++; if (b_seg !== 7'h00) begin failures++; $display("FAIL rst_b_seg got %h exp 00", b_seg); end
    checks++; if (c_seg !== 7'h7F) begin failures++; $display("FAIL rst_c_seg got %h exp 7f", c_seg); end
    checks++; if (c_an !== 5'b00000) begin failures++; $display("FAIL rst_c_an got %b exp 00000", c_an); end
    checks++; if (c_idx !== 3'd0) begin failures++; $display("FAIL rst_c_idx got %0d exp 0", c_idx); end
  endtask

  task automatic test_scan();
    seg_t pat [4];
    logic [3:0] exp_an;
    seg_t exp_seg;
    logic [1:0] exp_idx;
    logic exp_tick;
    int d, ph;
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    a_if.wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_if.wr_idx = 2'(i);
      a_if.wr_seg = pat[i];
      @(negedge clk);
    end
    a_if.wr_en = 1'b0;
    a_dis = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      d = (c / 6) % 4;
      ph = c % 6;
      if (ph < 2) begin
        exp_an = 4'hF;
        exp_seg = 7'h00;
        exp_idx = (c < 6) ? 2'd0 : 2'((d + 3) % 4);
      end else begin
        exp_an = ~(4'b0001 << d);
        exp_seg = pat[d];
        exp_idx = 2'(d);
      end
      exp_tick = (ph == 2) && (d == 0) && (c >= 6);
      checks++; if (a_an !== exp_an) begin failures++; $display("FAIL scan_an c=%0d got %h exp %h", c, a_an, exp_an); end
      checks++; if (a_seg !== exp_seg) begin failures++; $display("FAIL scan_seg c=%0d got %h exp %h", c, a_seg, exp_seg); end
      checks++; if (a_idx !== exp_idx) begin failures++; $display("FAIL scan_idx c=%0d got %0d exp %0d", c, a_idx, exp_idx); end
      checks++; if (a_tick !== exp_tick) begin failures++; $display("FAIL scan_tick c=%0d got %b exp %b", c, a_tick, exp_tick); end
    end
  endtask

  task automatic test_live_update();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (a_an === 4'hD) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL live_wait got timeout exp an=D");
    end else begin
      a_if.wr_en = 1'b1; a_if.wr_idx = 2'd1; a_if.wr_seg = 7'h7F;
      @(negedge clk);
      a_if.wr_en = 1'b0;
      checks++; if (a_seg !== 7'h06) begin failures++; $display("FAIL live_seg_k got %h exp 06", a_seg); end
      checks++; if (a_an !== 4'hD) begin failures++; $display("FAIL live_an_k got %h exp D", a_an); end
      @(negedge clk);
      checks++; if (a_seg !== 7'h7F) begin failures++; $display("FAIL live_seg_k1 got %h exp 7f", a_seg); end
      checks++; if (a_an !== 4'hD) begin failures++; $display("FAIL live_an_k1 got %h exp D", a_an); end
      checks++; if (a_idx !== 2'd1) begin failures++; $display("FAIL live_idx got %0d exp 1", a_idx); end
    end
  endtask

  task automatic test_disp_drop();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (a_an === 4'hB) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL drop_wait got timeout exp an=B");
    end else begin
      a_dis = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        checks++; if (a_an !== 4'hF) begin failures++; $display("FAIL drop_an i=%0d got %h exp F", i, a_an); end
        checks++; if (a_seg !== 7'h00) begin failures++; $display("FAIL drop_seg i=%0d got %h exp 00", i, a_seg); end
        checks++; if (a_idx !== 2'd0) begin failures++; $display("FAIL drop_idx i=%0d got %0d exp 0", i, a_idx); end
      end
      a_dis = 1'b1;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        checks++; if (a_an !== 4'hF) begin failures++; $display("FAIL reen_blank_an i=%0d got %h exp F", i, a_an); end
        checks++; if (a_idx !== 2'd0) begin failures++; $display("FAIL reen_blank_idx i=%0d got %0d exp 0", i, a_idx); end
      end
      @(negedge clk);
      checks++; if (a_an !== 4'hE) begin failures++; $display("FAIL reen_an got %h exp E", a_an); end
      checks++; if (a_seg !== 7'h3F) begin failures++; $display("FAIL reen_seg got %h exp 3f", a_seg); end
      checks++; if (a_idx !== 2'd0) begin failures++; $display("FAIL reen_idx got %0d exp 0", a_idx); end
      checks++; if (a_tick !== 1'b0) begin failures++; $display("FAIL reen_tick got %b exp 0", a_tick); end
    end
  endtask

  task automatic test_no_blank();
    logic [1:0] exp_an;
    seg_t exp_seg;
    logic exp_tick;
    int d;
    b_if.wr_en = 1'b1; b_if.wr_idx = 1'b0; b_if.wr_seg = 7'h5B;
    @(negedge clk);
    b_if.wr_idx = 1'b1; b_if.wr_seg = 7'h4F;
    @(negedge clk);
    b_if.wr_en = 1'b0;
    b_dis = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      d = (c / 3) % 2;
      exp_an = (d == 1) ? 2'b01 : 2'b10;
      exp_seg = (d == 1) ? 7'h4F : 7'h5B;
      exp_tick = (c % 6 == 0) && (c > 0);
      checks++; if (b_an !== exp_an) begin failures++; $display("FAIL nob_an c=%0d got %b exp %b", c, b_an, exp_an); end
      checks++; if (b_seg !== exp_seg) begin failures++; $display("FAIL nob_seg c=%0d got %h exp %h", c, b_seg, exp_seg); end
      checks++; if (b_idx !== 1'(d)) begin failures++; $display("FAIL nob_idx c=%0d got %0d exp %0d", c, b_idx, d); end
      checks++; if (b_tick !== exp_tick) begin failures++; $display("FAIL nob_tick c=%0d got %b exp %b", c, b_tick, exp_tick); end
    end
  endtask

  task automatic test_idx_range();
    logic [4:0] exp_an;
    seg_t exp_seg;
    logic [2:0] exp_idx;
    logic exp_tick;
    int d, ph;
    c_if.wr_en = 1'b1;
    c_if.wr_idx = 3'd0; c_if.wr_seg = 7'h06; @(negedge clk);
    c_if.wr_idx = 3'd4; c_if.wr_seg = 7'h66; @(negedge clk);
    c_if.wr_idx = 3'd5; c_if.wr_seg = 7'h7F; @(negedge clk);
    c_if.wr_idx = 3'd6; c_if.wr_seg = 7'h7F; @(negedge clk);
    c_if.wr_idx = 3'd7; c_if.wr_seg = 7'h5B; @(negedge clk);
    c_if.wr_en = 1'b0;
    c_dis = 1'b1;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      d = (c / 6) % 5;
      ph = c % 6;
      if (ph < 2) begin
        exp_an = 5'b00000;
        exp_seg = 7'h7F;
        exp_idx = (c < 6) ? 3'd0 : 3'((d + 4) % 5);
      end else begin
        exp_an = 5'b00001 << d;
        exp_seg = (d == 0) ? 7'h79 : (d == 4) ? 7'h19 : 7'h7F;
        exp_idx = 3'(d);
      end
      exp_tick = (ph == 2) && (d == 0) && (c >= 6);
      checks++; if (c_an !== exp_an) begin failures++; $display("FAIL rng_an c=%0d got %b exp %b", c, c_an, exp_an); end
      checks++; if (c_seg !== exp_seg) begin failures++; $display("FAIL rng_seg c=%0d got %h exp %h", c, c_seg, exp_seg); end
      checks++; if (c_idx !== exp_idx) begin failures++; $display("FAIL rng_idx c=%0d got %0d exp %0d", c, c_idx, exp_idx); end
      checks++; if (c_tick !== exp_tick) begin failures++; $display("FAIL rng_tick c=%0d got %b exp %b", c, c_tick, exp_tick); end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (a_an !== 4'hF) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL rmid_wait got timeout exp lit digit");
    end else begin
      #2 rst_n = 1'b0;
      #1;
      checks++; if (a_seg !== 7'h00) begin failures++; $display("FAIL rmid_seg got %h exp 00", a_seg); end
      checks++; if (a_an !== 4'hF) begin failures++; $display("FAIL rmid_an got %h exp F", a_an); end
      checks++; if (a_idx !== 2'd0) begin failures++; $display("FAIL rmid_idx got %0d exp 0", a_idx); end
      checks++; if (a_tick !== 1'b0) begin failures++; $display("FAIL rmid_tick got %b exp 0", a_tick); end
      checks++; if (c_seg !== 7'h7F) begin failures++; $display("FAIL rmid_c_seg got %h exp 7f", c_seg); end
      checks++; if (c_an !== 5'b00000) begin failures++; $display("FAIL rmid_c_an got %b exp 00000", c_an); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk);
      checks++; if (a_an !== 4'hE) begin failures++; $display("FAIL rmid_restart_an got %h exp E", a_an); end
      checks++; if (a_seg !== 7'h00) begin failures++; $display("FAIL rmid_buf_lost got %h exp 00", a_seg); end
    end
  endtask

  initial begin
    a_if.wr_en = 1'b0; a_if.wr_idx = '0; a_if.wr_seg = '0; a_dis = 1'b0;
    b_if.wr_en = 1'b0; b_if.wr_idx = '0; b_if.wr_seg = '0; b_dis = 1'b0;
    c_if.wr_en = 1'b0; c_if.wr_idx = '0; c_if.wr_seg = '0; c_dis = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset_values();
    test_scan();
    test_live_update();
    test_disp_drop();
    test_no_blank();
    test_idx_range();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
